// File: rtl/lsu_mem_master.sv
// Load/store initiator between the EX/MEM stage and a fixed-latency SRAM port.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses are reported as errors.
module lsu_mem_master #(
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        MemRead,
    output logic [3:0]  MemWrite,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_INIT = 2'((MEM_RD_LATENCY > 0) ? MEM_RD_LATENCY - 1 : 0);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_load_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        accept, req_err, misalign, issue_go, capture;
    logic [1:0]  req_off;
    logic        mem_read_d, rsp_valid_d, rsp_err_d;
    logic [3:0]  mem_write_d;
    logic [31:0] rsp_rdata_d;

    function automatic logic funct3_illegal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        else
            return f3[2] || (f3[1:0] == 2'b11);
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic        [31:0] lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = rdata >> {off, 3'b000};
        lane_b = $signed(lane[7:0]);
        lane_h = $signed(lane[15:0]);
        case (f3)
            3'b000:  return {{24{lane_b[7]}}, lane_b};
            3'b001:  return {{16{lane_h[15]}}, lane_h};
            3'b100:  return {24'b0, lane[7:0]};
            3'b101:  return {16'b0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_off  = req_addr[1:0];
    end
`else
    // Misaligned halfword/word accesses are silently snapped to natural alignment.
    always_comb begin
        misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_off = {req_addr[1], 1'b0};
            2'b10:   req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
    end
`endif

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = funct3_illegal(req_is_load, req_funct3) || misalign;
    assign issue_go  = accept && !req_err;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 4'b0000;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = req_err ? RESP : ISSUE;
                    rsp_err_d = req_err;
                    if (issue_go) begin
                        mem_read_d  = req_is_load;
                        mem_write_d = req_is_load ? 4'b0000 : store_strobe(req_funct3, req_off);
                    end
                end
            end
            ISSUE: begin
                if (!is_load_q) begin
                    state_d = RESP;
                end else if (MEM_RD_LATENCY == 0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    state_d    = WAIT;
                    cnt_d      = WAIT_INIT;
                    mem_read_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d      = cnt_q - 2'd1;
                    mem_read_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        rsp_rdata_d = capture ? load_extract(funct3_q, off_q, read_data) : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            MemRead    <= 1'b0;
            MemWrite   <= 4'b0000;
            address    <= 32'b0;
            write_data <= 32'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'b0;
            rsp_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            MemRead   <= mem_read_d;
            MemWrite  <= mem_write_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (issue_go) begin
                address    <= {req_addr[31:2], 2'b00};
                write_data <= store_lanes(req_funct3, req_wdata);
            end
        end
    end

    // Request fields are pure data; state reset alone keeps them from being used stale.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_load_q <= req_is_load;
            funct3_q  <= req_funct3;
            off_q     <= req_off;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: L=1 main instance plus L=0 and L=3 instances for latency checks.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_load = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic [31:0] read_data = 32'b0;

    logic        req_ready, rsp_valid, rsp_err, MemRead;
    logic [31:0] rsp_rdata, address, write_data;
    logic [3:0]  MemWrite;

    logic        rdy0, rv0, err0, mr0;
    logic [31:0] rd0, adr0, wd0;
    logic [3:0]  mw0;
    logic        rdy3, rv3, err3, mr3;
    logic [31:0] rd3, adr3, wd3;
    logic [3:0]  mw3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address), .write_data(write_data),
        .read_data(read_data)
    );

    lsu_mem_master #(.MEM_RD_LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_is_load(req_is_load), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0),
        .MemRead(mr0), .MemWrite(mw0), .address(adr0), .write_data(wd0),
        .read_data(read_data)
    );

    lsu_mem_master #(.MEM_RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_is_load(req_is_load), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3),
        .MemRead(mr3), .MemWrite(mw3), .address(adr3), .write_data(wd3),
        .read_data(read_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Observations of the most recent transaction, cycle 1 = first cycle after accept.
    int          rv_cyc, rv_cnt, mr_cnt, mw_cnt, both_cnt, rv0_cyc, rv3_cyc;
    logic [31:0] rv_data, rd0_data, rd3_data, addr1, wd1;
    logic        rv_err;
    logic [3:0]  mw1;

    task automatic run_req(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        rv_cyc = 0; rv_cnt = 0; mr_cnt = 0; mw_cnt = 0; both_cnt = 0;
        rv0_cyc = 0; rv3_cyc = 0; rv_data = 32'hx; rv_err = 1'bx;
        rd0_data = 32'hx; rd3_data = 32'hx;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mw1 = MemWrite; addr1 = address; wd1 = write_data;
            end
            if (MemRead) mr_cnt++;
            if (MemWrite != 4'b0000) mw_cnt++;
            if (MemRead && MemWrite != 4'b0000) both_cnt++;
            if (rsp_valid) begin
                rv_cnt++;
                if (rv_cyc == 0) begin
                    rv_cyc = c; rv_data = rsp_rdata; rv_err = rsp_err;
                end
            end
            if (rv0 && rv0_cyc == 0) begin rv0_cyc = c; rd0_data = rd0; end
            if (rv3 && rv3_cyc == 0) begin rv3_cyc = c; rd3_data = rd3; end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_wdata", write_data, 32'd0);
        check("rst_rsp", {rsp_valid, rsp_err, 30'b0}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // SW word store
        run_req(1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_strobe", 32'(mw1), 32'hF);
        check("sw_addr", addr1, 32'h100);
        check("sw_wdata", wd1, 32'hDEADBEEF);
        check("sw_rsp_cyc", rv_cyc, 2);
        check("sw_rsp_cnt", rv_cnt, 1);
        check("sw_mw_cycles", mw_cnt, 1);
        check("sw_no_read", mr_cnt, 0);
        check("sw_rdata", rv_data, 32'h0);
        check("sw_err", 32'(rv_err), 32'd0);

        // SB to top byte lane
        run_req(1'b0, 3'b000, 32'h103, 32'h000000A5);
        check("sb_strobe", 32'(mw1), 32'h8);
        check("sb_wdata", wd1, 32'hA5A5A5A5);
        check("sb_addr", addr1, 32'h100);
        check("sb_rsp_cyc", rv_cyc, 2);

        // SH to upper halfword
        run_req(1'b0, 3'b001, 32'h102, 32'h00001234);
        check("sh_strobe", 32'(mw1), 32'hC);
        check("sh_wdata", wd1, 32'h12341234);

        // LB / LBU sign and zero extension
        read_data = 32'hA5000000;
        run_req(1'b1, 3'b000, 32'h103, 32'h0);
        check("lb_rdata", rv_data, 32'hFFFFFFA5);
        check("lb_rsp_cyc", rv_cyc, 3);
        check("lb_read_cycles", mr_cnt, 2);
        check("lb_no_write", mw_cnt, 0);
        check("lb_addr", addr1, 32'h100);
        run_req(1'b1, 3'b100, 32'h103, 32'h0);
        check("lbu_rdata", rv_data, 32'h000000A5);

        // LH / LHU and latency variants
        read_data = 32'h80017FFF;
        run_req(1'b1, 3'b001, 32'h102, 32'h0);
        check("lh_rdata", rv_data, 32'hFFFF8001);
        check("lh_l0_rsp_cyc", rv0_cyc, 2);
        check("lh_l3_rsp_cyc", rv3_cyc, 5);
        check("lh_l0_rdata", rd0_data, 32'hFFFF8001);
        check("lh_l3_rdata", rd3_data, 32'hFFFF8001);
        run_req(1'b1, 3'b101, 32'h102, 32'h0);
        check("lhu_rdata", rv_data, 32'h00008001);
        run_req(1'b1, 3'b001, 32'h100, 32'h0);
        check("lh_low_rdata", rv_data, 32'h00007FFF);

        // Misaligned accesses snap to natural alignment
        read_data = 32'h11223344;
        run_req(1'b1, 3'b010, 32'h101, 32'h0);
        check("lw_mis_addr", addr1, 32'h100);
        check("lw_mis_rdata", rv_data, 32'h11223344);
        check("lw_mis_err", 32'(rv_err), 32'd0);
        read_data = 32'h80017FFF;
        run_req(1'b1, 3'b001, 32'h103, 32'h0);
        check("lh_mis_rdata", rv_data, 32'hFFFF8001);

        // Illegal funct3
        run_req(1'b0, 3'b100, 32'h100, 32'h12345678);
        check("st_ill_err", 32'(rv_err), 32'd1);
        check("st_ill_rsp_cyc", rv_cyc, 1);
        check("st_ill_no_write", mw_cnt, 0);
        check("st_ill_rdata", rv_data, 32'h0);
        run_req(1'b1, 3'b011, 32'h100, 32'h0);
        check("ld_ill_err", 32'(rv_err), 32'd1);
        check("ld_ill_no_read", mr_cnt, 0);
        check("ld_ill_rdata", rv_data, 32'h0);
        check("never_both", both_cnt, 0);

        // Back-to-back: second request waits until the cycle after RESP
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
        check("b2b_ready_t0", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("b2b_ready_t1", 32'(req_ready), 32'd0);
        check("b2b_strobe_t1", 32'(MemWrite), 32'hF);
        @(negedge clk);
        check("b2b_ready_t2", 32'(req_ready), 32'd0);
        check("b2b_rsp_t2", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("b2b_ready_t3", 32'(req_ready), 32'd1);
        check("b2b_idle_strobe", 32'(MemWrite), 32'h0);
        req_funct3 = 3'b000; req_addr = 32'h204; req_wdata = 32'h0000005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b2_strobe", 32'(MemWrite), 32'h1);
        check("b2b2_addr", address, 32'h204);
        check("b2b2_wdata", write_data, 32'h5A5A5A5A);
        repeat (6) @(negedge clk);

        // Reset during WAIT of a load
        read_data = 32'h11223344;
        req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rw_memread_wait", 32'(MemRead), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rw_memread_clr", 32'(MemRead), 32'd0);
        check("rw_no_rsp", 32'(rsp_valid), 32'd0);
        check("rw_ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rw_no_rsp_after", 32'(rsp_valid), 32'd0);
        check("rw_l3_no_rsp", 32'(rv3), 32'd0);
        check("rw_ready_after", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
